bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the 4-digit 7-segment display serializer and drives its 16-bit BCD input.
- Calculator result path: ALU result -> bin2bcd_seq -> display serializer.
- Holds the last converted value stable so the serializer can resample it every frame.

---
 rtl/calc_disp_pkg.sv | 15 +
 rtl/dd_nibble_adjust.sv | 17 +
 rtl/bin2bcd_seq.sv | 116 +++++++++++
 tb/tb_bin2bcd_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the calculator display path (bin2bcd_seq, display serializer).
package calc_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned BCD_MAX     = 9999;
    localparam int unsigned BCD_MAX_NEG = 999;
    localparam logic [15:0] OVF_PATTERN = 16'hFFFF;
    localparam logic [3:0]  NEG_NIBBLE  = 4'hA;

endpackage

// File: rtl/dd_nibble_adjust.sv
// Double-dabble correction: adds 3 to every BCD nibble that is 5 or more, nibble-local.
module dd_nibble_adjust (
    input  logic [15:0] din,
    output logic [15:0] dout
);

    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (din[i*4 +: 4] >= 4'd5)
                dout[i*4 +: 4] = din[i*4 +: 4] + 4'd3;
            else
                dout[i*4 +: 4] = din[i*4 +: 4];
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding the display serializer.
// Optional signed input handling is enabled with `define BIN2BCD_SIGNED_EN.
module bin2bcd_seq
    import calc_disp_pkg::*;
#(
    parameter int unsigned BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic [15:0]      bcd_out,
    output logic             valid,
    output logic             busy,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_t             state, state_nx;
    logic [BIN_W-1:0]   shreg;
    logic [15:0]        scratch;
    logic [15:0]        adj;
    logic [15:0]        scratch_sh;
    logic [15:0]        result;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pending;
    logic [BIN_W-1:0]   mag;
    logic               ovf_in;

`ifdef BIN2BCD_SIGNED_EN
    logic neg_in, neg;

    always_comb begin
        neg_in = bin_in[BIN_W-1];
        mag    = neg_in ? ('0 - bin_in) : bin_in;
        ovf_in = neg_in ? (32'(mag) > BCD_MAX_NEG) : (32'(mag) > BCD_MAX);
    end
`else
    always_comb begin
        mag    = bin_in;
        ovf_in = 32'(bin_in) > BCD_MAX;
    end
`endif

    dd_nibble_adjust u_adj (
        .din  (scratch),
        .dout (adj)
    );

    always_comb begin
        scratch_sh = (adj << 1) | {15'b0, shreg[BIN_W-1]};
`ifdef BIN2BCD_SIGNED_EN
        result = neg ? {NEG_NIBBLE, scratch_sh[11:0]} : scratch_sh;
`else
        result = scratch_sh;
`endif
    end

    // bcd_out is loaded on the edge leaving the last SHIFT so it is new in the DONE cycle, aligned with valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            scratch     <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            bcd_out     <= '0;
            overflow    <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            neg         <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg       <= mag;
                        scratch     <= '0;
                        cnt         <= CNT_W'(BIN_W);
                        ovf_pending <= ovf_in;
`ifdef BIN2BCD_SIGNED_EN
                        neg         <= neg_in;
`endif
                    end
                end
                SHIFT: begin
                    scratch <= scratch_sh;
                    shreg   <= shreg << 1;
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        bcd_out  <= ovf_pending ? OVF_PATTERN : result;
                        overflow <= ovf_pending;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        valid    = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nx = DONE;
            DONE: begin
                valid    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: arithmetic reference model, randomized and directed conversions.
module tb_bin2bcd_seq;

    localparam int unsigned BIN_W = 14;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic [15:0]      bcd_out;
    logic             valid;
    logic             busy;
    logic             overflow;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .bcd_out  (bcd_out),
        .valid    (valid),
        .busy     (busy),
        .overflow (overflow)
    );

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int unsigned due;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int unsigned acc = 0;
    bit          have_acc = 0;
    logic [15:0] hold_bcd = '0;
    logic        hold_ovf = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(int unsigned v);
        exp_t        e;
        int unsigned mag;
        bit          neg;
        neg = 0;
        mag = v;
`ifdef BIN2BCD_SIGNED_EN
        if (v >= 2**(BIN_W-1)) begin
            neg = 1;
            mag = 2**BIN_W - v;
        end
`endif
        e.due = 0;
        if (neg ? (mag > 999) : (mag > 9999)) begin
            e.bcd = 16'hFFFF;
            e.ovf = 1'b1;
        end else begin
            e.bcd = 16'((mag / 1000) * 4096 + (mag / 100 % 10) * 256 + (mag / 10 % 10) * 16 + mag % 10);
            if (neg) e.bcd[15:12] = 4'hA;
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Caller is at a negedge with the DUT idle at the next posedge.
    task automatic issue(input int unsigned v);
        exp_t e;
        start    = 1'b1;
        bin_in   = BIN_W'(v);
        acc      = cyc + 1;
        have_acc = 1;
        e        = model(v);
        e.due    = acc + BIN_W;
        q.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        bin_in = BIN_W'($urandom);
    endtask

    task automatic wait_idle();
        while (cyc < acc + BIN_W + 1) @(negedge clk);
    endtask

    // Monitor: samples 1 time unit after each active edge.
    initial begin
        exp_t e;
        bit   exp_busy;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                q.delete();
                hold_bcd = '0;
                hold_ovf = 1'b0;
                chk("reset_valid", valid, 0);
                chk("reset_busy", busy, 0);
                chk("reset_bcd", bcd_out, 0);
                chk("reset_ovf", overflow, 0);
            end else begin
                exp_busy = have_acc && (cyc >= acc) && (cyc <= acc + BIN_W);
                chk("busy", busy, exp_busy);
                if (valid) begin
                    if (q.size() == 0) begin
                        n_total++;
                        $display("FAIL spurious_valid: got valid=1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        e = q.pop_front();
                        chk("valid_latency", cyc, e.due);
                        hold_bcd = e.bcd;
                        hold_ovf = e.ovf;
                    end
                end else if (q.size() != 0 && cyc >= q[0].due) begin
                    e = q.pop_front();
                    n_total++;
                    $display("FAIL missing_valid: got valid=0 expected 1 (cycle %0d)", cyc);
                    hold_bcd = e.bcd;
                    hold_ovf = e.ovf;
                end
                chk("bcd_out", bcd_out, hold_bcd);
                chk("overflow", overflow, hold_ovf);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(0);     wait_idle();
        issue(1234);  wait_idle();
        issue(9999);  wait_idle();
        issue(10000); wait_idle();
        issue(7);     wait_idle();

        // start while busy must be ignored
        issue(4321);
        while (cyc < acc + 4) @(negedge clk);
        start  = 1'b1;
        bin_in = BIN_W'(5555);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // reset aborts a conversion in progress
        issue(8888);
        while (cyc < acc + 6) @(negedge clk);
        rst      = 1'b1;
        have_acc = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(42); wait_idle();

`ifdef BIN2BCD_SIGNED_EN
        issue(2**BIN_W - 42);   wait_idle();
        issue(2**BIN_W - 1000); wait_idle();
        issue(2**BIN_W - 999);  wait_idle();
        issue(2**(BIN_W-1));    wait_idle();
        issue(2**(BIN_W-1) - 1); wait_idle();
`endif

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue($urandom_range(0, 2**BIN_W - 1));
            wait_idle();
        end
        issue(2**BIN_W - 1); wait_idle();

        repeat (5) @(negedge clk);
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
